// File: rtl/disp_pkg.sv
// Shared definitions for the two-digit scanned 7-segment display driver:
// scan state encoding, blank/off constants and the active-low hex segment table.
package disp_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        GAP0 = 2'd1,
        DIG1 = 2'd2,
        GAP1 = 2'd3
    } scan_state_t;

    // Segments are {g,f,e,d,c,b,a}, active-low; anodes are {an1,an0}, active-low.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_DIG0 = 2'b10;
    localparam logic [1:0] AN_DIG1 = 2'b01;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/disp_scan2_hex7seg.sv
// Combinational 4-bit to 7-segment decoder, full hex 0-F, active-low segments.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Straight table lookup; every code has a glyph so no default is needed.
    always_comb begin
        seg = HEX_SEG[code];
    end

endmodule

// File: rtl/disp_scan2.sv
// Two-digit time-multiplexed common-anode 7-segment driver.
// Digit 0 shows the captured sq code, digit 1 the captured oea word, with
// all-off gap states between digits to suppress ghosting.
// Optional build macro BLANK_ZERO_EN: blank digit 1 when its captured value is 0.
module disp_scan2
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 16,
    parameter int CNT_W    = 16
) (
    input  logic       eck,
    input  logic       er,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    scan_state_t      state;
    scan_state_t      state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       cap0;
    logic [3:0]       cap1;
    logic [3:0]       dec_code;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_nx;
    logic [1:0]       an_nx;

    // Capture both digit codes together so the display never shows a torn pair.
    always_ff @(posedge eck or negedge er) begin
        if (!er) begin
            cap0 <= 4'h0;
            cap1 <= 4'h0;
        end else if (load) begin
            cap0 <= d0;
            cap1 <= d1;
        end
    end

    // Dwell/gap counter and scan sequencing; gap states are skipped when GAP_CYC is 0.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        if (((state == DIG0) || (state == DIG1)) ? (cnt == DIG_LAST) : (cnt == GAP_LAST)) begin
            cnt_nx = '0;
            unique case (state)
                DIG0:    state_nx = (GAP_CYC == 0) ? DIG1 : GAP0;
                GAP0:    state_nx = DIG1;
                DIG1:    state_nx = (GAP_CYC == 0) ? DIG0 : GAP1;
                GAP1:    state_nx = DIG0;
                default: state_nx = DIG0;
            endcase
        end
    end

    // Pick the digit that will be lit after this edge; the decoder sees the
    // current capture, so a new load shows up one cycle after its edge.
    always_comb begin
        dec_code = (state_nx == DIG1) ? cap1 : cap0;
    end

    hex7seg u_hex7seg (
        .code (dec_code),
        .seg  (dec_seg)
    );

    // Output selection from the next state so anodes and segments switch with the state.
    always_comb begin
        an_nx  = AN_OFF;
        seg_nx = SEG_OFF;
        unique case (state_nx)
            DIG0: begin
                an_nx  = AN_DIG0;
                seg_nx = dec_seg;
            end
            DIG1: begin
                an_nx  = AN_DIG1;
`ifdef BLANK_ZERO_EN
                seg_nx = (cap1 == 4'h0) ? SEG_OFF : dec_seg;
`else
                seg_nx = dec_seg;
`endif
            end
            default: begin
                an_nx  = AN_OFF;
                seg_nx = SEG_OFF;
            end
        endcase
    end

    // State, counter and registered outputs; reset blanks the display immediately.
    always_ff @(posedge eck or negedge er) begin
        if (!er) begin
            state <= DIG0;
            cnt   <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            an    <= an_nx;
            seg   <= seg_nx;
        end
    end

endmodule

// File: tb/tb_disp_scan2.sv
// Self-checking bench for disp_scan2: one instance with gaps (GAP_CYC=2) and
// one without (GAP_CYC=0), both SCAN_DIV=4, driven by the same inputs and
// compared every cycle against a timeline model of the scan.
module tb_disp_scan2;

    logic       eck;
    logic       er;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       load;
    logic [6:0] segGap;
    logic [1:0] anGap;
    logic [6:0] segNoGap;
    logic [1:0] anNoGap;

    int checkCount = 0;
    int failCount  = 0;

    // Model state: edges since reset release and the captured digit pair.
    int         tEdge = 0;
    logic [3:0] cap0M = 4'h0;
    logic [3:0] cap1M = 4'h0;

    logic [6:0] hexTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    disp_scan2 #(.SCAN_DIV(4), .GAP_CYC(2), .CNT_W(16)) dut_gap (
        .eck  (eck),
        .er   (er),
        .d0   (d0),
        .d1   (d1),
        .load (load),
        .seg  (segGap),
        .an   (anGap)
    );

    disp_scan2 #(.SCAN_DIV(4), .GAP_CYC(0), .CNT_W(16)) dut_nogap (
        .eck  (eck),
        .er   (er),
        .d0   (d0),
        .d1   (d1),
        .load (load),
        .seg  (segNoGap),
        .an   (anNoGap)
    );

    initial eck = 1'b0;
    always #5 eck = ~eck;

    // Which slot of the scan is showing t edges after release: 0=digit0, 1=gap, 2=digit1, 3=gap.
    function automatic int slotOf(int gap, int t);
        int p;
        p = t % (8 + 2 * gap);
        if (p < 4) return 0;
        if (p < 4 + gap) return 1;
        if (p < 8 + gap) return 2;
        return 3;
    endfunction

    function automatic logic [1:0] expAn(int slot);
        if (slot == 0) return 2'b10;
        if (slot == 2) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [6:0] expSeg(int slot, logic [3:0] c0, logic [3:0] c1);
        if (slot == 0) return hexTab[c0];
        if (slot == 2) begin
`ifdef BLANK_ZERO_EN
            if (c1 == 4'h0) return 7'h7F;
`endif
            return hexTab[c1];
        end
        return 7'h7F;
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checkCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, tEdge, obs, exp);
        end
    endtask

    task automatic checkAll(input logic [1:0] anG, input logic [6:0] segG,
                            input logic [1:0] anN, input logic [6:0] segN);
        checkOutput("gap_an",    {5'd0, anGap},    {5'd0, anG});
        checkOutput("gap_seg",   segGap,           segG);
        checkOutput("nogap_an",  {5'd0, anNoGap},  {5'd0, anN});
        checkOutput("nogap_seg", segNoGap,         segN);
    endtask

    // One clock edge with the given inputs, then compare both instances to the model.
    task automatic applyStimulus(input logic ld, input logic [3:0] v0, input logic [3:0] v1);
        int sg;
        int sn;
        load = ld;
        d0   = v0;
        d1   = v1;
        @(posedge eck);
        #1;
        tEdge++;
        sg = slotOf(2, tEdge);
        sn = slotOf(0, tEdge);
        checkAll(expAn(sg), expSeg(sg, cap0M, cap1M), expAn(sn), expSeg(sn, cap0M, cap1M));
        if (ld) begin
            cap0M = v0;
            cap1M = v1;
        end
    endtask

    // Asynchronous reset pulse started away from the clock edge; release mid-cycle.
    task automatic pulseReset;
        #2;
        er = 1'b0;
        #1;
        checkAll(2'b11, 7'h7F, 2'b11, 7'h7F);
        @(posedge eck);
        #1;
        checkAll(2'b11, 7'h7F, 2'b11, 7'h7F);
        er    = 1'b1;
        tEdge = 0;
        cap0M = 4'h0;
        cap1M = 4'h0;
    endtask

    initial begin
        er   = 1'b1;
        load = 1'b0;
        d0   = 4'h0;
        d1   = 4'h0;
        repeat (2) @(posedge eck);
        #1;

        $display("[TB] async reset and first digit");
        pulseReset();
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 4'h5, 4'h6);

        $display("[TB] capture 3/A and run the scan pattern");
        applyStimulus(1'b1, 4'h3, 4'hA);
        for (int i = 0; i < 26; i++) applyStimulus(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("[TB] load pulse inside digit 0");
        while ((tEdge % 12) != 1) applyStimulus(1'b0, 4'h1, 4'h2);
        applyStimulus(1'b1, 4'h8, 4'hA);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 4'h7, 4'h7);

        $display("[TB] reset during digit 1 count 2");
        while ((tEdge % 12) != 8) applyStimulus(1'b0, 4'h4, 4'h4);
        pulseReset();
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 4'h9, 4'h9);

        $display("[TB] zero on digit 1, F on digit 0");
        applyStimulus(1'b1, 4'hF, 4'h0);
        for (int i = 0; i < 26; i++) applyStimulus(1'b0, 4'h2, 4'h3);

        $display("[TB] randomized loads and resets");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset();
            end else begin
                applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
